// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types, constants and byte-level helpers.
// Byte 0 of a block sits at bits [0:7], so blk[8*i +: 8] is byte i.
// A column is packed as a [31:0] word with its first byte in [31:24].
package aes_pkg;

  typedef logic [0:127] block_t;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  // Round constants, indexed by round number 1..10.
  localparam logic [1:10][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] s;
    s = 8'h00;
    case (b)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
    endcase
    return s;
  endfunction

  // Multiply by x in GF(2^8), reducing with 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column: rows of the circulant matrix {02,03,01,01}.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_round.sv
// aes_round: one combinational AES-128 encryption round together with the
// matching key-schedule step. The new round key feeds AddRoundKey directly,
// so the core only has to register the two outputs. MixColumns is bypassed
// when last is high.
module aes_round
  import aes_pkg::*;
(
  input  logic [0:127] state,
  input  logic [0:127] rk,
  input  logic [7:0]   rcon,
  input  logic         last,
  output logic [0:127] next_state,
  output logic [0:127] next_rk
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sub_rot;
  logic [31:0] n0, n1, n2, n3;
  logic [7:0]  sb [16];
  block_t      mixed;

  // Key expansion: RotWord/SubWord on word 3, rcon into its first byte,
  // then the XOR chain across the four words.
  assign w0 = rk[0  +: 32];
  assign w1 = rk[32 +: 32];
  assign w2 = rk[64 +: 32];
  assign w3 = rk[96 +: 32];
  assign sub_rot = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
  assign n0 = w0 ^ sub_rot;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign next_rk = {n0, n1, n2, n3};

  // SubBytes on every byte of the state.
  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sb[i] = sbox(state[8*i +: 8]);
  end

  // ShiftRows picks row r of column c from column (c+r) mod 4, then
  // MixColumns unless this is the final round.
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [31:0] shifted;
    assign shifted = {sb[4*c], sb[4*((c+1)%4)+1], sb[4*((c+2)%4)+2], sb[4*((c+3)%4)+3]};
    assign mixed[32*c +: 32] = last ? shifted : mix_column(shifted);
  end

  assign next_state = mixed ^ next_rk;

endmodule

// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128 encryptor with valid/ready handshakes on
// input and output, one block in flight. Holds the FSM, round counter and
// registers; the round logic lives in aes_round.
// Build option: define AES_ITER_TWO_ROUND_EN to chain two round stages per
// clock (counter steps 1,3,5,7,9); the interface is unchanged.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int ROUNDS = 10
) (
  input  logic         ACLK,
  input  logic         ARESET,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] key,
  input  logic [0:127] plain_txt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] cipher_txt,
  output logic         busy
);

`ifdef AES_ITER_TWO_ROUND_EN
  localparam logic [3:0] STEP     = 4'd2;
  localparam logic [3:0] LAST_CNT = 4'(ROUNDS - 1);
`else
  localparam logic [3:0] STEP     = 4'd1;
  localparam logic [3:0] LAST_CNT = 4'(ROUNDS);
`endif

  state_t     fsm_q;
  block_t     data_q;
  block_t     rk_q;
  logic [3:0] cnt_q;
  block_t     round_state;
  block_t     round_key;

`ifdef AES_ITER_TWO_ROUND_EN
  block_t     mid_state;
  block_t     mid_rk;
  logic [3:0] cnt_odd;

  assign cnt_odd = cnt_q + 4'd1;

  aes_round u_round_a (
    .state      (data_q),
    .rk         (rk_q),
    .rcon       (RCON[cnt_q]),
    .last       (1'b0),
    .next_state (mid_state),
    .next_rk    (mid_rk)
  );

  aes_round u_round_b (
    .state      (mid_state),
    .rk         (mid_rk),
    .rcon       (RCON[cnt_odd]),
    .last       (cnt_q == LAST_CNT),
    .next_state (round_state),
    .next_rk    (round_key)
  );
`else
  aes_round u_round (
    .state      (data_q),
    .rk         (rk_q),
    .rcon       (RCON[cnt_q]),
    .last       (cnt_q == LAST_CNT),
    .next_state (round_state),
    .next_rk    (round_key)
  );
`endif

  // Ready only in IDLE and never while reset is held.
  assign in_ready = (fsm_q == IDLE) && !ARESET;

  // FSM, round counter and datapath registers; reset overrides any handshake.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      fsm_q      <= IDLE;
      data_q     <= '0;
      rk_q       <= '0;
      cnt_q      <= '0;
      cipher_txt <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            data_q <= plain_txt ^ key;
            rk_q   <= key;
            cnt_q  <= 4'd1;
            busy   <= 1'b1;
            fsm_q  <= ROUND;
          end
        end
        ROUND: begin
          data_q <= round_state;
          rk_q   <= round_key;
          cnt_q  <= cnt_q + STEP;
          if (cnt_q == LAST_CNT) begin
            cipher_txt <= round_state;
            out_valid  <= 1'b1;
            busy       <= 1'b0;
            fsm_q      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            fsm_q     <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_iter_core.sv
// tb_aes_iter_core: directed and randomized bench for aes_iter_core.
// The reference model builds its S-box from GF(2^8) inverses and the affine
// map, expands the whole key schedule up front, and runs AES-128 on byte
// arrays. Honours AES_ITER_TWO_ROUND_EN for latency/throughput.
module tb_aes_iter_core;

`ifdef AES_ITER_TWO_ROUND_EN
  localparam int LATENCY = 5;
  localparam int PERIOD  = 7;
`else
  localparam int LATENCY = 10;
  localparam int PERIOD  = 12;
`endif

  localparam logic [0:127] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         ACLK = 1'b0;
  logic         ARESET;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] key;
  logic [0:127] plain_txt;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] cipher_txt;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] sbox_tab [256];

  aes_iter_core dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .key        (key),
    .plain_txt  (plain_txt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .cipher_txt (cipher_txt),
    .busy       (busy)
  );

  always #5 ACLK = ~ACLK;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [0:127] aes_ref(input logic [0:127] k, input logic [0:127] p);
    logic [7:0] w [176];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] rc;
    logic [7:0] a [4];
    logic [0:127] res;
    for (int i = 0; i < 16; i++) w[i] = k[8*i +: 8];
    rc = 8'h01;
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
      if (i % 16 == 0) begin
        tmp[0] = sbox_tab[w[i-3]] ^ rc;
        tmp[1] = sbox_tab[w[i-2]];
        tmp[2] = sbox_tab[w[i-1]];
        tmp[3] = sbox_tab[w[i-4]];
        rc = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = p[8*i +: 8] ^ w[i];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_tab[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r + 4*c] = t[r + 4*((c + r) % 4)];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = s[4*c + r];
          for (int r = 0; r < 4; r++)
            s[4*c + r] = gmul(a[r], 8'h02) ^ gmul(a[(r+1)%4], 8'h03) ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rnd + i];
    end
    for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
    return res;
  endfunction

  function automatic logic [0:127] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a block and hold in_valid until the accept edge has passed.
  task automatic applyStimulus(input logic [0:127] k, input logic [0:127] p);
    int n;
    key = k;
    plain_txt = p;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checkOutput("accept_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic waitResult(output int edges);
    edges = 0;
    while (out_valid !== 1'b1 && edges < 40) begin
      step();
      edges++;
    end
  endtask

  int           edges;
  logic         accepting;
  logic         seen_valid;
  int           nres;
  int           cyc;
  logic [0:127] exp_q [$];
  int           res_cyc [$];

  initial begin
    ARESET = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    key = '0;
    plain_txt = '0;

    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv, b;
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
      b = inv;
      sbox_tab[v] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    end

    $display("[TB] reset");
    repeat (3) step();
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cipher", cipher_txt, 0);
    ARESET = 1'b0;
    #1;
    checkOutput("rel_in_ready", in_ready, 1);
    step();

    $display("[TB] FIPS-197 C.1 vector");
    applyStimulus(KEY_C1, PT_C1);
    checkOutput("c1_busy", busy, 1);
    waitResult(edges);
    checkOutput("c1_latency", edges, LATENCY);
    checkOutput("c1_ct", cipher_txt, CT_C1);
    checkOutput("c1_done_in_ready", in_ready, 0);
    out_ready = 1'b1;
    step();
    checkOutput("c1_release_valid", out_valid, 0);
    checkOutput("c1_release_in_ready", in_ready, 1);
    out_ready = 1'b0;

    $display("[TB] FIPS-197 B vector with back-pressure");
    applyStimulus(KEY_B, PT_B);
    waitResult(edges);
    checkOutput("b_latency", edges, LATENCY);
    checkOutput("b_ct", cipher_txt, CT_B);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        in_valid = 1'b1;
        key = rand128();
        plain_txt = rand128();
      end
      if (i == 6) in_valid = 1'b0;
      step();
      checkOutput("bp_valid", out_valid, 1);
      checkOutput("bp_ct", cipher_txt, CT_B);
      checkOutput("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    checkOutput("bp_release_valid", out_valid, 0);
    checkOutput("bp_release_in_ready", in_ready, 1);
    out_ready = 1'b0;
    step();
    checkOutput("bp_pulse_ignored", busy, 0);
    checkOutput("bp_ct_hold_idle", cipher_txt, CT_B);

    $display("[TB] input isolation");
    applyStimulus(KEY_C1, PT_C1);
    key = '1;
    plain_txt = '1;
    waitResult(edges);
    checkOutput("iso_latency", edges, LATENCY);
    checkOutput("iso_ct", cipher_txt, CT_C1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    $display("[TB] reset abort");
    applyStimulus(KEY_B, PT_B);
    repeat (4) step();
    checkOutput("abort_busy_before", busy, 1);
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    #1;
    checkOutput("abort_valid", out_valid, 0);
    checkOutput("abort_ct", cipher_txt, 0);
    checkOutput("abort_in_ready", in_ready, 1);
    checkOutput("abort_busy", busy, 0);
    seen_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      seen_valid = seen_valid | out_valid;
    end
    checkOutput("abort_no_pulse", seen_valid, 0);
    applyStimulus(KEY_C1, PT_C1);
    waitResult(edges);
    checkOutput("abort_fresh_latency", edges, LATENCY);
    checkOutput("abort_fresh_ct", cipher_txt, CT_C1);
    out_ready = 1'b1;
    step();

    $display("[TB] back-to-back random blocks");
    key = rand128();
    plain_txt = rand128();
    in_valid = 1'b1;
    out_ready = 1'b1;
    nres = 0;
    cyc = 0;
    while (nres < 4 && cyc < 200) begin
      accepting = in_ready && in_valid;
      step();
      cyc++;
      if (accepting) begin
        exp_q.push_back(aes_ref(key, plain_txt));
        key = rand128();
        plain_txt = rand128();
      end
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput("b2b_unexpected", out_valid, 0);
        end else begin
          checkOutput("b2b_ct", cipher_txt, exp_q.pop_front());
        end
        res_cyc.push_back(cyc);
        nres++;
        if (nres == 4) in_valid = 1'b0;
      end
    end
    checkOutput("b2b_count", nres, 4);
    for (int i = 1; i < res_cyc.size(); i++)
      checkOutput("b2b_period", res_cyc[i] - res_cyc[i-1], PERIOD);
    out_ready = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_iter_core.md
# aes_iter_core

Iterative, clocked AES-128 encryption engine that consumes the 128-bit key and plaintext held in the AXI-lite register bank and returns the ciphertext for readback. It replaces the purely combinational AES core behind the register bank with a multi-cycle datapath that has a valid/ready handshake on both sides. One block is in flight at a time. Byte 0 of each 128-bit vector sits at bits [0:7], MSB-first, matching the register-bank layout.

## Interface
- `ROUNDS`, default 10: AES-128 round count. Only 10 is supported.
- `ACLK`, input, 1: clock.
- `ARESET`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: key and plain_txt are valid.
- `in_ready`, output, 1: core can accept a block.
- `key`, input, [0:127]: cipher key, sampled on the accept edge.
- `plain_txt`, input, [0:127]: plaintext, sampled on the accept edge.
- `out_valid`, output, 1: cipher_txt holds a completed result.
- `out_ready`, input, 1: consumer accepts the result.
- `cipher_txt`, output, [0:127]: registered ciphertext.
- `busy`, output, 1: high in ROUND state (status bit for the register bank).

## Operation
- States:
  - IDLE: `in_ready`=1.
  - ROUND: a round counter runs 1..10.
  - DONE: `out_valid`=1.
- IDLE→ROUND on `in_valid && in_ready`:
  - state register <= plain_txt ^ key.
  - round-key register <= key.
  - round counter <= 1.
- Each ROUND cycle, with r = round counter:
  - Key step: rk' = KeyExpand(rk, rcon[r]). Rotate/substitute word 3, XOR rcon into its first byte, then chain the XOR across words 0..3.
  - Data step: state' = AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), rk').
  - MixColumns is skipped when r == 10.
- ROUND→DONE when r == 10: the final state is written to `cipher_txt`, and `out_valid` <= 1.
- DONE→IDLE on `out_valid && out_ready`. `cipher_txt` keeps its value until the next completion.
- `in_valid` is ignored outside IDLE. key and plain_txt may change freely after the accept edge.
- rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- MixColumns uses GF(2^8) with xtime reduction polynomial 0x11b.

## Timing
- Reset values:
  - `in_ready`=0 during reset, 1 on the first cycle after release.
  - `out_valid`=0, `busy`=0, `cipher_txt`=0.
  - state=IDLE, internal registers=0.
- `in_ready` is a combinational decode of state==IDLE. It does not depend on `in_valid`.
- Latency: `out_valid` rises on the 10th rising edge after the accept edge (5th with the macro below).
- Throughput: one block per 12 cycles when `out_ready` is held high. The DONE→IDLE cycle is not overlapped with a new accept.
- Back-pressure: `out_valid` stays high and `cipher_txt` stays stable indefinitely while `out_ready`=0.
- `out_ready` high in IDLE or ROUND has no effect.
- `ARESET` mid-ROUND or in DONE aborts the operation:
  - The next cycle is IDLE with `cipher_txt`=0.
  - No `out_valid` pulse is produced for the aborted block.
- `ARESET` has priority over every handshake in the same cycle.

## Configuration
- `AES_ITER_TWO_ROUND_EN` defined:
  - Two chained round stages per cycle.
  - The counter steps 1,3,5,7,9. The second stage of the counter==9 cycle is the final round without MixColumns.
  - Latency is 5 edges; throughput is one block per 7 cycles.
- Not defined: one round per cycle as above.
- The interface is identical in both builds.

## Structure
- Package `aes_pkg` holds:
  - the S-box function (256-entry case);
  - the rcon constant array;
  - `xtime` and `mix_column` functions;
  - the state enum (IDLE, ROUND, DONE);
  - a 128-bit block typedef.
- Sub-module `aes_round` is combinational. It takes inputs (state, rk, rcon, last) and produces outputs (state', rk').
  - It is instantiated once in the default build and twice when `AES_ITER_TWO_ROUND_EN` is defined.
  - `aes_iter_core` holds only the FSM, the counter and the registers.

## Test plan
- FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, pt=00112233445566778899aabbccddeeff. Expect ct=69c4e0d86a7b0430d8cdb78070b4c55a, with `out_valid` exactly 10 edges after accept (5 with the macro).
- FIPS-197 B: key=2b7e151628aed2a6abf7158809cf4f3c, pt=3243f6a8885a308d313198a2e0370734. Expect ct=3925841d02dc09fbdc118597196a0b32.
- Back-pressure: hold `out_ready`=0 for 20 cycles after completion. Require `out_valid`=1, stable `cipher_txt`, `in_ready`=0, and a second `in_valid` pulse ignored. Releasing `out_ready` returns the core to IDLE after one cycle.
- Input isolation: change key/plain_txt to all-ones on the cycle after accept. The ciphertext must still match the C.1 vector.
- Reset abort: assert `ARESET` for one cycle at round 5. Require `out_valid`=0, `cipher_txt`=0 and `in_ready`=1 after release. A fresh C.1 block then completes correctly.
- Back-to-back: run 4 random blocks with `in_valid` and `out_ready` tied high. Compare against the reference model and require one result every 12 cycles (7 with the macro).
